// File: rtl/dm_hart_ctrl.sv
// Debug-module hart run-control: drives halt strobes and resume requests toward the core
// and reports dmstatus. Optional resethaltreq support via `define DM_RESETHALTREQ_EN.
module dm_hart_ctrl #(
    parameter int unsigned RETRY_CYCLES   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 11
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dmactive_i,
    input  logic haltreq_i,
    input  logic resumereq_i,
    input  logic ackhavereset_i,
    input  logic setresethaltreq_i,
    input  logic clrresethaltreq_i,
    input  logic hart_reset_i,
    input  logic halted_i,
    output logic debug_strobe_o,
    output logic resume_req_o,
    output logic halted_o,
    output logic running_o,
    output logic resumeack_o,
    output logic havereset_o,
    output logic hasresethaltreq_o,
    output logic busy_o,
    output logic timeout_o
);

    typedef enum logic [1:0] {
        S_RUNNING,
        S_HALT_REQ,
        S_HALTED,
        S_RESUME_REQ
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT    = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_RETRY      = CNT_WIDTH'(RETRY_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_RETRY_LAST = CNT_WIDTH'(RETRY_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX        = '1;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic                 strobe_q, strobe_d;
    logic                 resumeack_q, resumeack_d;
    logic                 havereset_q, havereset_d;
    logic                 timeout_q, timeout_d;
    logic                 rh_fire;       // reset-release halt request this cycle
    logic                 rh_pending_q;  // current HALT_REQ was started by resethaltreq

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

`ifdef DM_RESETHALTREQ_EN
    logic rh_latch_q, rh_latch_d;
    logic rh_pending_d;
    logic hart_reset_q;

    assign rh_fire           = rh_latch_q & hart_reset_q & ~hart_reset_i;
    assign hasresethaltreq_o = 1'b1;

    always_comb begin
        rh_latch_d = rh_latch_q;
        if (!dmactive_i) begin
            rh_latch_d = 1'b0;
        end else if (!hart_reset_i) begin
            if (setresethaltreq_i)      rh_latch_d = 1'b1;
            else if (clrresethaltreq_i) rh_latch_d = 1'b0;
        end
        // Pending survives only while we stay in the HALT_REQ it started.
        rh_pending_d = (state_d == S_HALT_REQ) &&
                       ((state_q == S_HALT_REQ) ? rh_pending_q : rh_fire);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rh_latch_q   <= 1'b0;
            rh_pending_q <= 1'b0;
            hart_reset_q <= 1'b0;
        end else begin
            rh_latch_q   <= rh_latch_d;
            rh_pending_q <= rh_pending_d;
            hart_reset_q <= hart_reset_i;
        end
    end
`else
    logic unused_resethaltreq;

    assign rh_fire             = 1'b0;
    assign rh_pending_q        = 1'b0;
    assign hasresethaltreq_o   = 1'b0;
    assign unused_resethaltreq = setresethaltreq_i | clrresethaltreq_i;
`endif

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        cnt_d       = cnt_q;
        strobe_d    = 1'b0;
        resumeack_d = resumeack_q;
        havereset_d = havereset_q;
        timeout_d   = timeout_q;

        if (!dmactive_i) begin
            state_d     = S_RUNNING;
            cnt_d       = '0;
            resumeack_d = 1'b0;
            timeout_d   = 1'b0;
        end else if (hart_reset_i) begin
            state_d     = S_RUNNING;
            cnt_d       = '0;
            resumeack_d = 1'b0;
            havereset_d = 1'b1;
        end else begin
            if (ackhavereset_i) havereset_d = 1'b0;

            unique case (state_q)
                S_RUNNING: begin
                    if (halted_i) begin
                        state_d = S_HALTED;
                    end else if (haltreq_i || rh_fire) begin
                        state_d  = S_HALT_REQ;
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                    end
                end
                S_HALT_REQ: begin
                    if (halted_i) begin
                        state_d = S_HALTED;
                    end else if (!(haltreq_i || rh_pending_q)) begin
                        state_d = S_RUNNING;
                    end else if (cnt_q == CNT_TIMEOUT) begin
                        state_d   = S_RUNNING;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d    = cnt_inc;
                        // Strobe is registered, so decide on the count the next cycle will hold.
                        strobe_d = ((cnt_inc % CNT_RETRY) == CNT_RETRY_LAST);
                    end
                end
                S_HALTED: begin
                    if (resumereq_i && !haltreq_i) begin
                        state_d     = S_RESUME_REQ;
                        resumeack_d = 1'b0;
                        cnt_d       = '0;
                    end else if (!halted_i) begin
                        state_d = S_RUNNING;
                    end
                end
                S_RESUME_REQ: begin
                    if (!halted_i) begin
                        state_d     = S_RUNNING;
                        resumeack_d = 1'b1;
                    end else if (cnt_q == CNT_TIMEOUT) begin
                        state_d   = S_HALTED;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = S_RUNNING;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst_i) begin
            state_q     <= S_RUNNING;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            resumeack_q <= 1'b0;
            havereset_q <= 1'b1;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            resumeack_q <= resumeack_d;
            havereset_q <= havereset_d;
            timeout_q   <= timeout_d;
        end
    end

    assign debug_strobe_o = strobe_q;
    assign resume_req_o   = (state_q == S_RESUME_REQ);
    assign halted_o       = (state_q == S_HALTED)  || (state_q == S_RESUME_REQ);
    assign running_o      = (state_q == S_RUNNING) || (state_q == S_HALT_REQ);
    assign busy_o         = (state_q == S_HALT_REQ) || (state_q == S_RESUME_REQ);
    assign resumeack_o    = resumeack_q;
    assign havereset_o    = havereset_q;
    assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// Directed self-checking bench for dm_hart_ctrl (default parameters); also exercises
// the DM_RESETHALTREQ_EN build when that macro is defined.
module tb_dm_hart_ctrl;

    logic clk_i = 1'b0;
    logic rst_i, dmactive_i, haltreq_i, resumereq_i, ackhavereset_i;
    logic setresethaltreq_i, clrresethaltreq_i, hart_reset_i, halted_i;
    logic debug_strobe_o, resume_req_o, halted_o, running_o, resumeack_o;
    logic havereset_o, hasresethaltreq_o, busy_o, timeout_o;

    int n_cmp = 0;
    int n_err = 0;
    int pulses;

`ifdef DM_RESETHALTREQ_EN
    localparam logic RH_EN = 1'b1;
`else
    localparam logic RH_EN = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    dm_hart_ctrl dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .dmactive_i       (dmactive_i),
        .haltreq_i        (haltreq_i),
        .resumereq_i      (resumereq_i),
        .ackhavereset_i   (ackhavereset_i),
        .setresethaltreq_i(setresethaltreq_i),
        .clrresethaltreq_i(clrresethaltreq_i),
        .hart_reset_i     (hart_reset_i),
        .halted_i         (halted_i),
        .debug_strobe_o   (debug_strobe_o),
        .resume_req_o     (resume_req_o),
        .halted_o         (halted_o),
        .running_o        (running_o),
        .resumeack_o      (resumeack_o),
        .havereset_o      (havereset_o),
        .hasresethaltreq_o(hasresethaltreq_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n clock edges; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; dmactive_i = 1'b1; haltreq_i = 1'b0; resumereq_i = 1'b0;
        ackhavereset_i = 1'b0; setresethaltreq_i = 1'b0; clrresethaltreq_i = 1'b0;
        hart_reset_i = 1'b0; halted_i = 1'b0;
        tick(2);
        check("rst_running",   running_o, 1);
        check("rst_havereset", havereset_o, 1);
        check("rst_halted",    halted_o, 0);
        check("rst_strobe",    debug_strobe_o, 0);
        check("rst_resume",    resume_req_o, 0);
        check("rst_busy",      busy_o, 0);
        check("rst_timeout",   timeout_o, 0);
        check("rst_resumeack", resumeack_o, 0);
        check("hasresethaltreq", hasresethaltreq_o, 32'(RH_EN));
        rst_i = 1'b0;
        tick();

        ackhavereset_i = 1'b1; tick(); ackhavereset_i = 1'b0;
        check("ack_clears_havereset", havereset_o, 0);

        // Halt request answered 3 cycles after the strobe.
        haltreq_i = 1'b1;
        tick();
        check("halt_first_strobe", debug_strobe_o, 1);
        check("halt_busy", busy_o, 1);
        pulses = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(debug_strobe_o);
        end
        halted_i = 1'b1;
        tick(); pulses += int'(debug_strobe_o);
        tick(); pulses += int'(debug_strobe_o);
        check("halt_strobe_count", pulses, 1);
        check("halt_halted", halted_o, 1);
        check("halt_running", running_o, 0);
        check("halt_busy_done", busy_o, 0);

        // Resume request while haltreq is still high is ignored.
        resumereq_i = 1'b1; tick(); resumereq_i = 1'b0;
        check("ign_resume_req", resume_req_o, 0);
        check("ign_halted", halted_o, 1);
        tick();
        check("ign_halted_later", halted_o, 1);

        // Resume; core drops halted 4 cycles into RESUME_REQ.
        haltreq_i = 1'b0;
        tick();
        resumereq_i = 1'b1; tick(); resumereq_i = 1'b0;
        check("res_ack_low", resumeack_o, 0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            pulses += int'(resume_req_o);
            if (i < 3) tick();
        end
        halted_i = 1'b0;
        tick();
        check("res_req_cycles", pulses, 4);
        check("res_req_dropped", resume_req_o, 0);
        check("res_resumeack", resumeack_o, 1);
        check("res_running", running_o, 1);

        // Core-initiated halt and spontaneous resume.
        halted_i = 1'b1; tick();
        check("core_halt_halted", halted_o, 1);
        check("core_halt_no_strobe", debug_strobe_o, 0);
        halted_i = 1'b0; tick();
        check("core_resume_running", running_o, 1);

        // Unanswered halt: strobes at HALT_REQ cycles 0,15,31,...,1023 then timeout.
        haltreq_i = 1'b1;
        pulses = 0;
        for (int k = 0; k < 1024; k++) begin
            tick();
            pulses += int'(debug_strobe_o);
            if (k < 40)
                check($sformatf("retry_strobe_%0d", k), debug_strobe_o,
                      32'((k == 0) || (k % 16 == 15)));
            if (k == 1022) begin
                check("retry_busy_1022", busy_o, 1);
                check("retry_timeout_1022", timeout_o, 0);
            end
        end
        check("retry_strobe_total", pulses, 65);
        tick();
        haltreq_i = 1'b0;
        check("to_running", running_o, 1);
        check("to_busy", busy_o, 0);
        check("to_timeout", timeout_o, 1);
        check("to_strobe", debug_strobe_o, 0);
        tick();
        check("to_sticky", timeout_o, 1);

        // Abort by dropping haltreq.
        haltreq_i = 1'b1; tick();
        check("abort_busy", busy_o, 1);
        haltreq_i = 1'b0; tick();
        check("abort_running", running_o, 1);
        check("abort_not_busy", busy_o, 0);

        // hart_reset and ackhavereset together: set wins.
        hart_reset_i = 1'b1; ackhavereset_i = 1'b1; tick();
        hart_reset_i = 1'b0; ackhavereset_i = 1'b0;
        check("hr_havereset_set", havereset_o, 1);
        check("hr_resumeack_clr", resumeack_o, 0);
        check("hr_timeout_held", timeout_o, 1);
        tick();
        ackhavereset_i = 1'b1; tick(); ackhavereset_i = 1'b0;
        check("hr_ack_clears", havereset_o, 0);

        // Spontaneous resume does not set resumeack.
        halted_i = 1'b1; tick();
        halted_i = 1'b0; tick();
        check("spont_resumeack", resumeack_o, 0);
        check("spont_running", running_o, 1);

        // dmactive low clears timeout.
        dmactive_i = 1'b0; tick();
        check("dmact_timeout", timeout_o, 0);
        check("dmact_running", running_o, 1);
        dmactive_i = 1'b1; tick();

        // Unanswered resume times out back to HALTED.
        halted_i = 1'b1; tick();
        resumereq_i = 1'b1; tick(); resumereq_i = 1'b0;
        check("rto_req", resume_req_o, 1);
        tick(1023);
        check("rto_req_last", resume_req_o, 1);
        check("rto_timeout_before", timeout_o, 0);
        tick();
        check("rto_req_drop", resume_req_o, 0);
        check("rto_halted", halted_o, 1);
        check("rto_timeout", timeout_o, 1);
        halted_i = 1'b0; tick();
        dmactive_i = 1'b0; tick(); dmactive_i = 1'b1; tick();

        // Halt on reset release (only when resethaltreq support is built in).
        setresethaltreq_i = 1'b1; tick(); setresethaltreq_i = 1'b0;
        hart_reset_i = 1'b1; tick(2);
        hart_reset_i = 1'b0;
        pulses = 0;
        tick(); pulses += int'(debug_strobe_o);
        tick(); pulses += int'(debug_strobe_o);
        check("rh_strobe_count", pulses, 32'(RH_EN));
        check("rh_busy", busy_o, 32'(RH_EN));
        halted_i = 1'b1; tick();
        check("rh_halted", halted_o, 1);
        halted_i = 1'b0; tick(2);
        check("rh_running_end", running_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dm_hart_ctrl.md
Name: dm_hart_ctrl

Overview:
- Debug-module-side hart run-control engine; the initiator end of the halt/resume handshake that the core's debug controller answers.
- Converts dmcontrol-level requests (haltreq, resumereq, ackhavereset) from the DMI register file into a halt strobe and a resume request toward the core.
- Tracks the core's halted indication and produces dmstatus bits (halted/running/resumeack/havereset), busy and a sticky timeout flag.

Parameters:
- RETRY_CYCLES, 16, cycles in HALT_REQ without halted_i before the halt strobe is re-pulsed.
- TIMEOUT_CYCLES, 1024, cycles in HALT_REQ or RESUME_REQ before the request is abandoned.
- CNT_WIDTH, 11, wait-counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  processor clock.
- rst_i  in  1  asynchronous, active-high reset.
- dmactive_i  in  1  dmcontrol.dmactive; low acts as a synchronous soft reset.
- haltreq_i  in  1  dmcontrol.haltreq level.
- resumereq_i  in  1  one-cycle pulse: dmcontrol write with resumereq=1.
- ackhavereset_i  in  1  one-cycle pulse: dmcontrol write with ackhavereset=1.
- setresethaltreq_i  in  1  one-cycle pulse (optional feature).
- clrresethaltreq_i  in  1  one-cycle pulse (optional feature).
- hart_reset_i  in  1  hart/ndm reset level, active-high.
- halted_i  in  1  core halted indication.
- debug_strobe_o  out  1  one-cycle halt request pulse to the core.
- resume_req_o  out  1  resume request level to the core.
- halted_o  out  1  dmstatus.allhalted/anyhalted.
- running_o  out  1  dmstatus.allrunning/anyrunning.
- resumeack_o  out  1  dmstatus.allresumeack.
- havereset_o  out  1  dmstatus.allhavereset.
- hasresethaltreq_o  out  1  dmstatus.hasresethaltreq.
- busy_o  out  1  request in flight.
- timeout_o  out  1  sticky request-timeout flag.

Behaviour:
- Reset (rst_i async): state RUNNING, counter 0.
  - All outputs 0 except running_o=1 and havereset_o=1.
- FSM states: RUNNING, HALT_REQ, HALTED, RESUME_REQ. All transitions are registered.
- Priority order each cycle: rst_i, then dmactive_i=0, then hart_reset_i=1, then the FSM.
  - dmactive_i=0: same values as reset, except havereset is held.
  - hart_reset_i=1: force RUNNING, counter 0, resumeack 0, havereset set. timeout_o and the resethaltreq latch are held.
- RUNNING:
  - halted_i=1 → HALTED. This covers core-initiated halts (ebreak, step, trigger).
  - Else haltreq_i=1 → HALT_REQ, counter cleared; debug_strobe_o=1 in the first HALT_REQ cycle.
- HALT_REQ:
  - halted_i=1 → HALTED.
  - Else haltreq_i=0 → RUNNING (abort).
  - Else the counter increments. debug_strobe_o re-pulses for one cycle each time counter mod RETRY_CYCLES == RETRY_CYCLES-1.
  - When counter reaches TIMEOUT_CYCLES-1 → RUNNING and timeout_o set.
- HALTED:
  - resumereq_i=1 with haltreq_i=0 → RESUME_REQ, resumeack cleared, counter cleared.
  - resumereq_i with haltreq_i=1 is ignored.
  - halted_i=0 with no request → RUNNING; resumeack is not set.
- RESUME_REQ:
  - resume_req_o=1 throughout.
  - halted_i=0 → RUNNING and resumeack set (sticky until the next accepted resumereq).
  - When counter reaches TIMEOUT_CYCLES-1 → HALTED and timeout_o set.
- Status outputs:
  - halted_o = state in {HALTED, RESUME_REQ}.
  - running_o = state in {RUNNING, HALT_REQ}.
  - busy_o = state in {HALT_REQ, RESUME_REQ}.
  - All outputs are registered or decoded from registered state; none depend combinationally on inputs.
- havereset and timeout_o:
  - havereset is set by hart_reset_i and cleared by ackhavereset_i; set wins when both occur in the same cycle.
  - timeout_o is cleared only by rst_i or dmactive_i=0.
- Counter saturates and never wraps.
- debug_strobe_o is never asserted outside HALT_REQ.

Optional Feature:
- Macro DM_RESETHALTREQ_EN.
- Defined:
  - setresethaltreq_i sets a resethaltreq latch; clrresethaltreq_i clears it. Set wins when both pulse in the same cycle.
  - hasresethaltreq_o=1.
  - On the hart_reset_i falling edge (registered edge detect) with the latch set, enter HALT_REQ on the next cycle with strobe, exactly as if haltreq_i were high. The haltreq_i=0 abort is suppressed for this request.
- Undefined:
  - Set/clr inputs ignored; the latch does not exist.
  - hasresethaltreq_o=0; reset release leaves the FSM in RUNNING.

Test Plan:
- haltreq_i=1; halted_i rises 3 cycles after the strobe → exactly one debug_strobe_o pulse; halted_o=1 and running_o=0 two cycles after halted_i rises.
- haltreq_i=1, halted_i held 0, defaults → strobe pulses at HALT_REQ cycles 0, 15, 31, …; at cycle 1023 FSM returns to RUNNING with timeout_o=1.
- In HALTED, pulse resumereq_i; core drops halted_i 4 cycles later → resume_req_o high for those 4 cycles; then resumeack_o=1, running_o=1.
- In HALTED with haltreq_i=1, pulse resumereq_i → resume_req_o stays 0, state stays HALTED.
- Pulse hart_reset_i and ackhavereset_i in the same cycle → havereset_o=1; a later ackhavereset_i alone → 0.
- DM_RESETHALTREQ_EN defined, setresethaltreq pulsed, hart_reset_i asserted then released → one strobe pulse within 2 cycles of the release; halted_o=1 after the core halts.
